i2c_slave_sda: RTL and testbench
================================

Name: i2c_slave_sda

Overview:
- I2C responder (slave) for the SDA line, the counterpart of the master SDA/SCL blocks on the same bus.
- Oversamples SCL and SDA with the local system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then either receives bytes (master write) or transmits bytes (master read).
- Presents bytes to local logic through simple strobe handshakes.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on scl_in and sda_s before edge detection (min 2).

Ports:
- clk  input  1  system clock; f_clk >= 8 x f_SCL.
- reset  input  1  asynchronous, active-low reset.
- scl_in  input  1  SCL line from bus (slave never stretches the clock).
- sda_s  inout  1  open-drain SDA; driven 0 or released to 1'bz, never driven 1.
- slave_a  input  7  own address; sampled when the 8th address bit is captured.
- tx_data  input  8  byte to send on a master read; sampled on tx_load.
- rx_ack_en  input  1  1 = ACK received data bytes, 0 = NACK.
- rx_data  output  8  last received data byte; held until next byte.
- rx_valid  output  1  1-cycle pulse, rx_data updated the same cycle.
- tx_load  output  1  1-cycle pulse, tx_data consumed this cycle.
- addr_match  output  1  high from address ACK until STOP or START.
- stop_det  output  1  1-cycle pulse on each STOP seen while not IDLE.

Behaviour:
- Reset (async, reset=0): state IDLE, SDA released, bit counter 0, rx_data=0. rx_valid, tx_load, addr_match and stop_det are all 0.
- Sync and edge detection: scl and sda pass through SYNC_STAGES flops plus one "previous" register.
  - scl_rise / scl_fall: synced SCL 0->1 / 1->0.
  - START: synced SDA 1->0 while synced SCL = 1.
  - STOP: synced SDA 0->1 while synced SCL = 1.
- Timing: all SDA drive changes happen only in the cycle scl_fall is detected. SDA is sampled only on scl_rise.
- bit_cnt is 4 bits, counts 0..8 and clears on every state entry.
- States (4-bit): IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- Global priority: START in any state -> ADDR, release SDA, clear bit_cnt and addr_match. STOP in any non-IDLE state -> IDLE, release SDA, pulse stop_det. START/STOP outrank SCL edges detected in the same cycle.
- IDLE: wait for START.
- ADDR: shift SDA in MSB first on each scl_rise; bit 8 is r_w. On the scl_fall after the 8th rise:
  - shift[7:1] == slave_a: drive SDA 0, set addr_match, latch r_w, go to ADDR_ACK.
  - otherwise: go to WAIT_STOP with SDA released.
- ADDR_ACK: on scl_fall:
  - r_w=0: release SDA, go to RX.
  - r_w=1: pulse tx_load, load tx_data into the shift register, drive bit 7, go to TX.
- RX: shift on scl_rise. On the scl_fall after the 8th rise: update rx_data, pulse rx_valid, drive SDA 0 if rx_ack_en else release, go to RX_ACK.
- RX_ACK: on scl_fall, release SDA and go to RX.
- TX: on each scl_rise increment bit_cnt. On scl_fall with bit_cnt < 8, drive the next bit (1 means released). On scl_fall with bit_cnt == 8, release SDA and go to TX_ACK.
- TX_ACK: sample the master's ACK on scl_rise. On scl_fall:
  - ACK=0: pulse tx_load, reload, drive bit 7, go to TX.
  - NACK: release SDA, go to WAIT_STOP.
- WAIT_STOP: SDA released; leave only on STOP or START.
- Repeated START mid-byte aborts the byte: no rx_valid, partial shift discarded.
- General call (address 0x00) is not supported; it is treated as a mismatch unless slave_a = 0.

Decomposition:
- Shared package i2c_pkg: 4-bit state encodings and the I2C_BITS=8 constant. The master blocks reuse the same package.
- Natural sub-module: i2c_bus_sync. It covers the SCL/SDA synchronizer and the scl_rise/scl_fall/start/stop detector, and is reusable by the master for arbitration/ACK sampling.

Test Plan:
- Write, address match: slave_a=7'h3A; master sends START, 0x74, 0xA5, STOP -> SDA low during both ACK clocks; rx_valid pulses once with rx_data=8'hA5; stop_det pulses once; state returns to IDLE.
- Address mismatch: slave_a=7'h3A; master sends 0x76 -> SDA never driven (stays Z), no pulses, WAIT_STOP until STOP.
- Read, 2 bytes: tx_data=8'hC3, then 8'h5E after the first tx_load; master sends 0x75, ACK after byte 1, NACK after byte 2 -> bus carries C3 then 5E; tx_load pulses exactly twice; SDA released after the NACK.
- NACK data: rx_ack_en=0; write 0x11 -> rx_valid with 8'h11, and SDA released (high) at the 9th clock.
- Repeated START mid-byte: START injected after 4 data bits -> no rx_valid; state ADDR; the next address 0x75 is ACKed correctly.
- Async reset: reset=0 asserted while driving ACK -> SDA released immediately, all outputs 0, state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus state encodings and the byte width.
// Used by both the responder and the master-side blocks.
package i2c_pkg;

   localparam int unsigned I2C_BITS = 8;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      RX        = 4'd3,
      RX_ACK    = 4'd4,
      TX        = 4'd5,
      TX_ACK    = 4'd6,
      WAIT_STOP = 4'd7
   } i2c_state_e;

endpackage

// File: rtl/i2c_slave_sda_if.sv
// Local-side handshake of the I2C responder: address, byte strobes and status.
// The "master" modport is the local logic that feeds and consumes bytes.
interface i2c_slave_sda_if;

   logic [6:0] slave_a;
   logic [7:0] tx_data;
   logic       rx_ack_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_load;
   logic       addr_match;
   logic       stop_det;

   modport master (
      output slave_a, tx_data, rx_ack_en,
      input  rx_data, rx_valid, tx_load, addr_match, stop_det
   );

   modport slave (
      input  slave_a, tx_data, rx_ack_en,
      output rx_data, rx_valid, tx_load, addr_match, stop_det
   );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
// Flops reset to 1 so an idle (pulled-up) bus produces no spurious events.
module i2c_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda   = sda_sync_q[SYNC_STAGES-1];

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_d = scl_s;
      sda_prev_d = sda;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   assign start    = scl_s & sda_prev_q & ~sda;
   assign stop     = scl_s & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_slave_sda.sv
// I2C responder: 7-bit address match, byte receive/transmit with ACK handling.
// SDA is open-drain; all drive changes happen on the detected SCL fall.
module i2c_slave_sda
   import i2c_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            scl_in,
   inout  wire             sda_s,
   i2c_slave_sda_if.slave  host
);

   localparam logic [3:0] BIT_LAST = 4'(I2C_BITS);

   i2c_state_e          state_q, state_d;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [I2C_BITS-1:0] shift_q, shift_d;
   logic [I2C_BITS-1:0] rx_data_q, rx_data_d;
   logic                rw_q, rw_d;
   logic                ack_q, ack_d;
   logic                sda_oe_q, sda_oe_d;
   logic                rx_valid_q, rx_valid_d;
   logic                addr_match_q, addr_match_d;
   logic                stop_det_q, stop_det_d;
   logic                tx_load;
   logic                sda, scl_rise, scl_fall, start, stop;
   logic                addr_hit, stop_abort;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .scl_in   (scl_in),
      .sda_in   (sda_s),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign addr_hit   = (shift_q[I2C_BITS-1:1] == host.slave_a);
   assign stop_abort = stop && (state_q != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         rx_data_q    <= '0;
         rw_q         <= 1'b0;
         ack_q        <= 1'b1;
         sda_oe_q     <= 1'b0;
         rx_valid_q   <= 1'b0;
         addr_match_q <= 1'b0;
         stop_det_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rw_q         <= rw_d;
         ack_q        <= ack_d;
         sda_oe_q     <= sda_oe_d;
         rx_valid_q   <= rx_valid_d;
         addr_match_q <= addr_match_d;
         stop_det_q   <= stop_det_d;
      end
   end

   // Bus conditions outrank SCL edges seen in the same cycle.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ADDR;
      end else if (stop_abort) begin
         state_d = IDLE;
      end else if (scl_fall) begin
         case (state_q)
            ADDR:     if (bit_cnt_q == BIT_LAST) state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK: state_d = rw_q ? TX : RX;
            RX:       if (bit_cnt_q == BIT_LAST) state_d = RX_ACK;
            RX_ACK:   state_d = RX;
            TX:       if (bit_cnt_q == BIT_LAST) state_d = TX_ACK;
            TX_ACK:   state_d = ack_q ? WAIT_STOP : TX;
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      rw_d         = rw_q;
      ack_d        = ack_q;
      sda_oe_d     = sda_oe_q;
      rx_valid_d   = 1'b0;
      addr_match_d = addr_match_q;
      stop_det_d   = 1'b0;
      tx_load      = 1'b0;
      if (start) begin
         sda_oe_d     = 1'b0;
         addr_match_d = 1'b0;
         shift_d      = '0;
      end else if (stop_abort) begin
         sda_oe_d     = 1'b0;
         addr_match_d = 1'b0;
         stop_det_d   = 1'b1;
      end else begin
         if (scl_rise) begin
            case (state_q)
               ADDR, RX: begin
                  shift_d   = {shift_q[I2C_BITS-2:0], sda};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
               TX:      bit_cnt_d = bit_cnt_q + 4'd1;
               TX_ACK:  ack_d = sda;
               default: ;
            endcase
         end
         if (scl_fall) begin
            case (state_q)
               ADDR: begin
                  if (bit_cnt_q == BIT_LAST) begin
                     sda_oe_d = addr_hit;
                     if (addr_hit) begin
                        addr_match_d = 1'b1;
                        rw_d         = shift_q[0];
                     end
                  end
               end
               ADDR_ACK, TX_ACK: begin
                  if ((state_q == ADDR_ACK) ? rw_q : !ack_q) begin
                     tx_load  = 1'b1;
                     shift_d  = host.tx_data;
                     sda_oe_d = ~host.tx_data[I2C_BITS-1];
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end
               RX: begin
                  if (bit_cnt_q == BIT_LAST) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_oe_d   = host.rx_ack_en;
                  end
               end
               RX_ACK: sda_oe_d = 1'b0;
               TX: begin
                  if (bit_cnt_q == BIT_LAST) begin
                     sda_oe_d = 1'b0;
                  end else begin
                     shift_d  = {shift_q[I2C_BITS-2:0], 1'b0};
                     sda_oe_d = ~shift_q[I2C_BITS-2];
                  end
               end
               default: sda_oe_d = 1'b0;
            endcase
         end
      end
      // START re-enters ADDR from ADDR, so it must clear the counter explicitly.
      if (start || (state_d != state_q)) bit_cnt_d = '0;
   end

   assign sda_s           = sda_oe_q ? 1'b0 : 1'bz;
   assign host.rx_data    = rx_data_q;
   assign host.rx_valid   = rx_valid_q;
   assign host.tx_load    = tx_load;
   assign host.addr_match = addr_match_q;
   assign host.stop_det   = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_sda.sv
// Bench for i2c_slave_sda: a bit-level bus master plus a transaction-level
// expectation model (ACK bits, received bytes, strobe counts) per transfer.
module tb_i2c_slave_sda;
   import i2c_pkg::*;

   localparam int Q = 6;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic scl = 1'b1;
   logic sda_m = 1'b1;
   wire  sda;

   assign sda = sda_m ? 1'bz : 1'b0;
   pullup (sda);

   i2c_slave_sda_if bus_if ();

   i2c_slave_sda #(.SYNC_STAGES(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .scl_in (scl),
      .sda_s  (sda),
      .host   (bus_if.slave)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         rx_cnt = 0;
   int         tx_cnt = 0;
   int         stop_cnt = 0;
   logic [7:0] rx_last = '0;
   bit         drove = 1'b0;
   logic [7:0] pay [4];

   always @(negedge clk) begin
      if (bus_if.rx_valid) begin
         rx_cnt++;
         rx_last = bus_if.rx_data;
      end
      if (bus_if.tx_load) tx_cnt++;
      if (bus_if.stop_det) stop_cnt++;
      if (sda_m && sda === 1'b0) drove = 1'b1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wq();
      scl   = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl   = 1'b0; wq();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wq();
      scl   = 1'b1; wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic send_bit(input logic b, output logic s);
      sda_m = b; wq();
      scl   = 1'b1; wq();
      s     = sda; wq();
      scl   = 1'b0; wq();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
      send_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic dummy;
      for (int i = 7; i >= 0; i--) send_bit(1'b1, b[i]);
      send_bit(mack, dummy);
   endtask

   // Expectations come from the transfer description: address equality decides
   // ACK, writes are counted per byte, reads return the queued bytes in order.
   task automatic run_xfer(input logic [6:0] sa, input logic [7:0] addr_byte,
                           input int n, input logic ack_en, input string tag);
      logic       match, rw, a;
      logic [7:0] b;
      int         rx0, tx0, st0;
      match = (addr_byte[7:1] == sa);
      rw    = addr_byte[0];
      bus_if.slave_a   = sa;
      bus_if.rx_ack_en = ack_en;
      bus_if.tx_data   = pay[0];
      rx0 = rx_cnt; tx0 = tx_cnt; st0 = stop_cnt;
      bus_start();
      drove = 1'b0;
      write_byte(addr_byte, a);
      check({tag, " addr_ack"}, 32'(a), match ? 32'd0 : 32'd1);
      check({tag, " addr_match"}, 32'(bus_if.addr_match), 32'(match));
      if (!match) begin
         write_byte(pay[0], a);
         check({tag, " nomatch_ack"}, 32'(a), 32'd1);
         check({tag, " nomatch_drive"}, 32'(drove), 32'd0);
         check({tag, " nomatch_state"}, 32'(dut.state_q), 32'(WAIT_STOP));
      end else if (!rw) begin
         for (int i = 0; i < n; i++) begin
            write_byte(pay[i], a);
            check({tag, " data_ack"}, 32'(a), ack_en ? 32'd0 : 32'd1);
            check({tag, " rx_data"}, 32'(rx_last), 32'(pay[i]));
         end
      end else begin
         for (int i = 0; i < n; i++) begin
            if (i + 1 < n) bus_if.tx_data = pay[i + 1];
            read_byte(i == n - 1, b);
            check({tag, " rd_byte"}, 32'(b), 32'(pay[i]));
         end
         check({tag, " released_after_nack"}, 32'(sda), 32'd1);
      end
      bus_stop();
      check({tag, " rx_count"}, 32'(rx_cnt - rx0), (match && !rw) ? 32'(n) : 32'd0);
      check({tag, " tx_count"}, 32'(tx_cnt - tx0), (match && rw) ? 32'(n) : 32'd0);
      check({tag, " stop_count"}, 32'(stop_cnt - st0), 32'd1);
      check({tag, " idle"}, 32'(dut.state_q), 32'(IDLE));
      check({tag, " match_clr"}, 32'(bus_if.addr_match), 32'd0);
   endtask

   initial begin
      logic       a, dummy;
      logic [7:0] b, ab;
      logic [6:0] sa, a7;
      int         rx0, tx0, st0;

      bus_if.slave_a   = 7'h3A;
      bus_if.tx_data   = '0;
      bus_if.rx_ack_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst sda", 32'(sda), 32'd1);
      check("rst rx_data", 32'(bus_if.rx_data), 32'd0);
      check("rst rx_valid", 32'(bus_if.rx_valid), 32'd0);
      check("rst tx_load", 32'(bus_if.tx_load), 32'd0);
      check("rst addr_match", 32'(bus_if.addr_match), 32'd0);
      check("rst stop_det", 32'(bus_if.stop_det), 32'd0);
      check("rst state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b1;
      wq();

      pay[0] = 8'hA5;
      run_xfer(7'h3A, 8'h74, 1, 1'b1, "wr");
      run_xfer(7'h3A, 8'h76, 1, 1'b1, "mismatch");
      pay[0] = 8'hC3; pay[1] = 8'h5E;
      run_xfer(7'h3A, 8'h75, 2, 1'b1, "rd2");
      pay[0] = 8'h11;
      run_xfer(7'h3A, 8'h74, 1, 1'b0, "nack");
      pay[0] = 8'h00;
      run_xfer(7'h00, 8'h00, 1, 1'b1, "gencall");

      // Repeated START four bits into a data byte.
      bus_if.slave_a = 7'h3A;
      rx0 = rx_cnt; tx0 = tx_cnt;
      bus_start();
      write_byte(8'h74, a);
      check("rs addr_ack", 32'(a), 32'd0);
      send_bit(1'b1, dummy); send_bit(1'b0, dummy);
      send_bit(1'b1, dummy); send_bit(1'b1, dummy);
      bus_start();
      check("rs state", 32'(dut.state_q), 32'(ADDR));
      check("rs match_clr", 32'(bus_if.addr_match), 32'd0);
      bus_if.tx_data = 8'h96;
      write_byte(8'h75, a);
      check("rs addr2_ack", 32'(a), 32'd0);
      read_byte(1'b1, b);
      check("rs rd_byte", 32'(b), 32'h96);
      bus_stop();
      check("rs rx_count", 32'(rx_cnt - rx0), 32'd0);
      check("rs tx_count", 32'(tx_cnt - tx0), 32'd1);

      for (int it = 0; it < 8; it++) begin
         sa = 7'($urandom_range(0, 127));
         a7 = ($urandom_range(0, 3) != 0) ? sa : 7'($urandom);
         for (int k = 0; k < 4; k++) pay[k] = 8'($urandom);
         run_xfer(sa, {a7, 1'($urandom)}, int'($urandom_range(1, 3)), 1'($urandom), "rnd");
      end

      // Asynchronous reset while the address ACK is being driven.
      bus_if.slave_a = 7'h3A;
      st0 = stop_cnt;
      ab = 8'h74;
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(ab[i], dummy);
      sda_m = 1'b1; wq();
      check("ar ack_driven", 32'(sda), 32'd0);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("ar sda", 32'(sda), 32'd1);
      check("ar rx_data", 32'(bus_if.rx_data), 32'd0);
      check("ar addr_match", 32'(bus_if.addr_match), 32'd0);
      check("ar tx_load", 32'(bus_if.tx_load), 32'd0);
      check("ar rx_valid", 32'(bus_if.rx_valid), 32'd0);
      check("ar state", 32'(dut.state_q), 32'(IDLE));
      @(posedge clk);
      #1 reset = 1'b1;
      bus_stop();
      check("ar idle_stop", 32'(stop_cnt - st0), 32'd0);
      check("ar state_end", 32'(dut.state_q), 32'(IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
